// File: rtl/dr_share_host_bridge.sv
// Host-side bridge: splits single-rail words into two dual-rail Boolean shares,
// drives them to the fabric with spacer/evaluate phasing, then completion-detects
// the returning shares and recombines them into a single-rail result.
module dr_share_host_bridge #(
    parameter int W       = 23,
    parameter int PRE_CYC = 2,
    parameter int STABLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         resetn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic [W-1:0] s_mask,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_err,
    output logic [W-1:0] to_fab_0t,
    output logic [W-1:0] to_fab_0f,
    output logic [W-1:0] to_fab_1t,
    output logic [W-1:0] to_fab_1f,
    input  logic [W-1:0] from_fab_0t,
    input  logic [W-1:0] from_fab_0f,
    input  logic [W-1:0] from_fab_1t,
    input  logic [W-1:0] from_fab_1f,
    output logic [W-1:0] to_fab_oeb
);

    localparam int PW = (PRE_CYC > 1) ? $clog2(PRE_CYC + 1) : 1;
    localparam int SW = (STABLE > 1) ? $clog2(STABLE + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_CYC - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_EVAL,
        S_WAIT_EVAL,
        S_WAIT_SPACER,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_pre_cnt, w_pre_nxt;
    logic [SW-1:0] r_stab_cnt, w_stab_nxt;
    logic [TW-1:0] r_to_cnt, w_to_nxt;
    logic [W-1:0]  r_sh0, r_sh1;
    logic [W-1:0]  r_in_0t, r_in_0f, r_in_1t, r_in_1f;
    logic [W-1:0]  r_to_0t, r_to_0f, r_to_1t, r_to_1f;
    logic [W-1:0]  r_oeb;
    logic [W-1:0]  r_m_data;
    logic          r_m_err;
    logic          r_err;
    logic          r_s_ready;
    logic          w_accept, w_capture, w_finish, w_timeout;
    logic          w_in_wait, w_err_now, w_drive_nxt;
    logic [W-1:0]  w_comp, w_spacer, w_illegal;

    assign w_comp    = (r_in_0t ^ r_in_0f) & (r_in_1t ^ r_in_1f);
    assign w_spacer  = ~(r_in_0t | r_in_0f | r_in_1t | r_in_1f);
    assign w_illegal = (r_in_0t & r_in_0f) | (r_in_1t & r_in_1f);

    assign w_in_wait   = (r_state == S_WAIT_EVAL) || (r_state == S_WAIT_SPACER);
    assign w_err_now   = r_err | (w_in_wait & (|w_illegal));
    assign w_drive_nxt = (w_next == S_EVAL) || (w_next == S_WAIT_EVAL);

    assign s_ready    = r_s_ready;
    assign m_valid    = (r_state == S_DONE);
    assign m_data     = r_m_data;
    assign m_err      = r_m_err;
    assign to_fab_0t  = r_to_0t;
    assign to_fab_0f  = r_to_0f;
    assign to_fab_1t  = r_to_1t;
    assign to_fab_1f  = r_to_1f;
    assign to_fab_oeb = r_oeb;

    // Next-state logic: phase sequencing, stability and timeout counting
    always_comb begin
        w_next     = r_state;
        w_pre_nxt  = r_pre_cnt;
        w_stab_nxt = r_stab_cnt;
        w_to_nxt   = r_to_cnt;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_finish   = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_valid && r_s_ready) begin
                    w_accept  = 1'b1;
                    w_pre_nxt = '0;
                    w_next    = S_PRE;
                end
            end
            S_PRE: begin
                if (r_pre_cnt == PRE_LAST) begin
                    w_next = S_EVAL;
                end else begin
                    w_pre_nxt = r_pre_cnt + 1'b1;
                end
            end
            S_EVAL: begin
                w_stab_nxt = '0;
                w_to_nxt   = '0;
                w_next     = S_WAIT_EVAL;
            end
            S_WAIT_EVAL: begin
                w_to_nxt = r_to_cnt + 1'b1;
                if (r_to_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end else if (&w_comp) begin
                    if (r_stab_cnt == STAB_LAST) begin
                        w_capture  = 1'b1;
                        w_stab_nxt = '0;
                        w_to_nxt   = '0;
                        w_next     = S_WAIT_SPACER;
                    end else begin
                        w_stab_nxt = r_stab_cnt + 1'b1;
                    end
                end else begin
                    w_stab_nxt = '0;
                end
            end
            S_WAIT_SPACER: begin
                w_to_nxt = r_to_cnt + 1'b1;
                if (r_to_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end else if (&w_spacer) begin
                    if (r_stab_cnt == STAB_LAST) begin
                        w_finish   = 1'b1;
                        w_stab_nxt = '0;
                        w_next     = S_DONE;
                    end else begin
                        w_stab_nxt = r_stab_cnt + 1'b1;
                    end
                end else begin
                    w_stab_nxt = '0;
                end
            end
            S_DONE: begin
                if (m_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, counters, share latches, registered pin drivers and result capture
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_pre_cnt  <= '0;
            r_stab_cnt <= '0;
            r_to_cnt   <= '0;
            r_sh0      <= '0;
            r_sh1      <= '0;
            r_in_0t    <= '0;
            r_in_0f    <= '0;
            r_in_1t    <= '0;
            r_in_1f    <= '0;
            r_to_0t    <= '0;
            r_to_0f    <= '0;
            r_to_1t    <= '0;
            r_to_1f    <= '0;
            r_oeb      <= '1;
            r_m_data   <= '0;
            r_m_err    <= 1'b0;
            r_err      <= 1'b0;
            r_s_ready  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pre_cnt  <= w_pre_nxt;
            r_stab_cnt <= w_stab_nxt;
            r_to_cnt   <= w_to_nxt;
            r_in_0t    <= from_fab_0t;
            r_in_0f    <= from_fab_0f;
            r_in_1t    <= from_fab_1t;
            r_in_1f    <= from_fab_1f;
            r_s_ready  <= (w_next == S_IDLE);
            r_oeb      <= (w_next == S_IDLE) ? '1 : '0;
            r_to_0t    <= w_drive_nxt ? r_sh0 : '0;
            r_to_0f    <= w_drive_nxt ? ~r_sh0 : '0;
            r_to_1t    <= w_drive_nxt ? r_sh1 : '0;
            r_to_1f    <= w_drive_nxt ? ~r_sh1 : '0;
            if (w_accept) begin
                r_sh0 <= s_data ^ s_mask;
                r_sh1 <= s_mask;
                r_err <= 1'b0;
            end else if (w_in_wait) begin
                r_err <= w_err_now;
            end
            if (w_timeout) begin
                r_m_data <= '0;
                r_m_err  <= 1'b1;
            end else begin
                if (w_capture) begin
                    r_m_data <= r_in_0t ^ r_in_1t;
                end
                if (w_finish) begin
                    r_m_err <= w_err_now;
                end
            end
        end
    end

endmodule
